fpu_issue_ctrl: RTL and testbench

//  Shares the single multi-cycle fpu between two requesters (pipeline float ports 0/1).

---
 rtl/fpu_issue_ctrl_pkg.sv | 32 +++
 rtl/fpu_issue_ctrl_rr_arb2.sv | 11 +
 rtl/fpu_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: opcodes, word fields, controller states.
package fpu_issue_ctrl_pkg;

    localparam int DATA_W   = 16;
    localparam int OP_W     = 5;
    localparam int RD_W     = 4;
    localparam int SIGN_BIT = DATA_W - 1;

    localparam logic [OP_W-1:0] OP_ADDF = 5'h11;
    localparam logic [OP_W-1:0] OP_FTOI = 5'h12;
    localparam logic [OP_W-1:0] OP_ITOF = 5'h13;
    localparam logic [OP_W-1:0] OP_MULF = 5'h14;
    localparam logic [OP_W-1:0] OP_RECF = 5'h15;
    localparam logic [OP_W-1:0] OP_SUBF = 5'h16;

    typedef enum logic [1:0] {
        CTL_IDLE  = 2'd0,
        CTL_ISSUE = 2'd1,
        CTL_WAIT  = 2'd2,
        CTL_RESP  = 2'd3
    } ctl_state_t;

    // The legal opcodes form one contiguous range, ADDF..SUBF.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op >= OP_ADDF) && (op <= OP_SUBF);
    endfunction

    function automatic logic [DATA_W-1:0] negate_word(input logic [DATA_W-1:0] w);
        return {~w[SIGN_BIT], w[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | last_grant);
    assign grant[1] = valid[1] & (~valid[0] | ~last_grant);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Shares one multi-cycle FPU between two requesters; latches the granted op, drives the FPU,
// and returns the result (or an error on illegal opcode / timeout) with requester id and tag.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int MAX_LAT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*OP_W-1:0]    req_instr,
    input  logic [2*DATA_W-1:0]  req_op1,
    input  logic [2*DATA_W-1:0]  req_op2,
    input  logic [2*RD_W-1:0]    req_rd,
    output logic                 fpu_en,
    output logic [OP_W-1:0]      fpu_instr,
    output logic [DATA_W-1:0]    fpu_op1,
    output logic [DATA_W-1:0]    fpu_op2,
    input  logic [DATA_W-1:0]    fpu_result,
    input  logic                 fpu_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [RD_W-1:0]      rsp_rd,
    output logic [DATA_W-1:0]    rsp_result,
    output logic                 rsp_err,
    output logic                 busy
);

    // cnt holds the number of enable cycles already completed, so the
    // WAIT cycle seeing MAX_LAT-1 is the last of MAX_LAT enable cycles.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LAT - 1);

    ctl_state_t        state;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              gid;
    logic [OP_W-1:0]   sel_instr;
    logic [DATA_W-1:0] sel_op1;
    logic [DATA_W-1:0] sel_op2;
    logic [RD_W-1:0]   sel_rd;

    rr_arb2 u_arb (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign gid       = grant[1];
    assign sel_instr = gid ? req_instr[2*OP_W-1:OP_W]     : req_instr[OP_W-1:0];
    assign sel_op1   = gid ? req_op1[2*DATA_W-1:DATA_W]   : req_op1[DATA_W-1:0];
    assign sel_op2   = gid ? req_op2[2*DATA_W-1:DATA_W]   : req_op2[DATA_W-1:0];
    assign sel_rd    = gid ? req_rd[2*RD_W-1:RD_W]        : req_rd[RD_W-1:0];

    assign req_ready = (state == CTL_IDLE) ? grant : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CTL_IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            fpu_en     <= 1'b0;
            fpu_instr  <= '0;
            fpu_op1    <= '0;
            fpu_op2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_rd     <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                CTL_IDLE: begin
                    if (|grant) begin
                        last_grant <= gid;
                        rsp_id     <= gid;
                        rsp_rd     <= sel_rd;
                        busy       <= 1'b1;
                        if (op_is_legal(sel_instr)) begin
                            // SUBF runs on the FPU as ADDF with op2 negated.
                            fpu_instr <= (sel_instr == OP_SUBF) ? OP_ADDF : sel_instr;
                            fpu_op1   <= sel_op1;
                            fpu_op2   <= (sel_instr == OP_SUBF) ? negate_word(sel_op2) : sel_op2;
                            fpu_en    <= 1'b1;
                            state     <= CTL_ISSUE;
                        end else begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state      <= CTL_RESP;
                        end
                    end
                end
                CTL_ISSUE: begin
                    // fpu_done here still belongs to the previous op.
                    cnt   <= CNT_W'(1);
                    state <= CTL_WAIT;
                end
                CTL_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (fpu_done) begin
                        rsp_result <= fpu_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        fpu_en     <= 1'b0;
                        state      <= CTL_RESP;
                    end else if (cnt == LAST_CNT) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        fpu_en     <= 1'b0;
                        state      <= CTL_RESP;
                    end
                end
                CTL_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= CTL_IDLE;
                    end
                end
                default: begin
                    state <= CTL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with an FPU stub of programmable latency (0 = never done).
module tb_fpu_issue_ctrl;

    localparam int MAX_LAT = 16;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_instr;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [7:0]  req_rd;
    logic        fpu_en;
    logic [4:0]  fpu_instr;
    logic [15:0] fpu_op1;
    logic [15:0] fpu_op2;
    logic [15:0] fpu_result;
    logic        fpu_done;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [3:0]  rsp_rd;
    logic [15:0] rsp_result;
    logic        rsp_err;
    logic        busy;

    fpu_issue_ctrl #(.MAX_LAT(MAX_LAT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
        .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd),
        .fpu_en(fpu_en), .fpu_instr(fpu_instr), .fpu_op1(fpu_op1), .fpu_op2(fpu_op2),
        .fpu_result(fpu_result), .fpu_done(fpu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU stub: done is registered and sticky until the next op starts.
    int          stub_lat;
    int          stub_cnt;
    logic        en_q;
    logic [4:0]  seen_instr;
    logic [15:0] seen_op2;

    function automatic logic [15:0] stub_calc(input logic [4:0] i, input logic [15:0] a,
                                              input logic [15:0] b);
        if (i == 5'h13 && b == 16'h0001) return 16'h3F80;
        if (i == 5'h11 && a == 16'h4000 && b == 16'hBF80) return 16'h3F80;
        return a ^ b ^ {11'd0, i};
    endfunction

    initial begin
        fpu_done   = 1'b0;
        fpu_result = 16'h0;
        en_q       = 1'b0;
        stub_cnt   = 0;
    end

    always @(posedge clk) begin
        en_q <= fpu_en;
        if (fpu_en && !en_q) begin
            stub_cnt = 1;
            seen_instr <= fpu_instr;
            seen_op2   <= fpu_op2;
            if (stub_lat == 1) begin
                fpu_done   <= 1'b1;
                fpu_result <= stub_calc(fpu_instr, fpu_op1, fpu_op2);
            end else begin
                fpu_done <= 1'b0;
            end
        end else if (fpu_en) begin
            stub_cnt = stub_cnt + 1;
            if (stub_lat != 0 && stub_cnt == stub_lat) begin
                fpu_done   <= 1'b1;
                fpu_result <= stub_calc(fpu_instr, fpu_op1, fpu_op2);
            end
        end
    end

    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [4:0]  instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  rd;
        int          lat;
        logic [15:0] exp_result;
        logic        exp_err;
        int          exp_en;
        logic [4:0]  exp_fi;
        logic [15:0] exp_fop2;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic id, input logic [4:0] instr, input logic [15:0] op1,
                                input logic [15:0] op2, input logic [3:0] rd, input int lat,
                                input logic [15:0] res, input logic err, input int en,
                                input logic [4:0] fi, input logic [15:0] fop2);
        vec_t v;
        v.id = id; v.instr = instr; v.op1 = op1; v.op2 = op2; v.rd = rd; v.lat = lat;
        v.exp_result = res; v.exp_err = err; v.exp_en = en; v.exp_fi = fi; v.exp_fop2 = fop2;
        return v;
    endfunction

    task automatic present(input logic id, input logic [4:0] instr, input logic [15:0] op1,
                           input logic [15:0] op2, input logic [3:0] rd);
        if (id) begin
            req_instr[9:5] = instr; req_op1[31:16] = op1; req_op2[31:16] = op2; req_rd[7:4] = rd;
        end else begin
            req_instr[4:0] = instr; req_op1[15:0] = op1; req_op2[15:0] = op2; req_rd[3:0] = rd;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int en_cnt;
        int cyc;
        int bad;
        logic [1:0] mask;
        en_cnt = 0; cyc = 0; bad = 0;
        mask = v.id ? 2'b10 : 2'b01;
        @(negedge clk);
        stub_lat = v.lat;
        present(v.id, v.instr, v.op1, v.op2, v.rd);
        req_valid = mask;
        #1;
        check($sformatf("v%0d_req_ready", idx), {30'd0, req_ready}, {30'd0, mask});
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        while (!rsp_valid && cyc <= 40) begin
            if (fpu_en) begin
                en_cnt++;
                if (fpu_instr !== v.exp_fi || fpu_op2 !== v.exp_fop2) bad++;
            end
            cyc++;
            @(negedge clk);
        end
        check($sformatf("v%0d_rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("v%0d_latency", idx), cyc, v.exp_en);
        check($sformatf("v%0d_en_cycles", idx), en_cnt, v.exp_en);
        check($sformatf("v%0d_rsp_id", idx), {31'd0, rsp_id}, {31'd0, v.id});
        check($sformatf("v%0d_rsp_rd", idx), {28'd0, rsp_rd}, {28'd0, v.rd});
        check($sformatf("v%0d_rsp_result", idx), {16'd0, rsp_result}, {16'd0, v.exp_result});
        check($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
        if (v.exp_en > 0) begin
            check($sformatf("v%0d_fpu_instr", idx), {27'd0, seen_instr}, {27'd0, v.exp_fi});
            check($sformatf("v%0d_fpu_op2", idx), {16'd0, seen_op2}, {16'd0, v.exp_fop2});
            check($sformatf("v%0d_fpu_hold", idx), bad, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_idle_busy", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_idle_rsp_valid", idx), {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        int seen_rsp;
        checks = 0; errors = 0;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req_instr = '0; req_op1 = '0; req_op2 = '0; req_rd = '0;
        stub_lat = 1;

        vecs[0]  = mk(1'b0, 5'h13, 16'h0000, 16'h0001, 4'd3, 3,  16'h3F80, 1'b0, 4,  5'h11 + 5'h02, 16'h0001);
        vecs[1]  = mk(1'b1, 5'h16, 16'h4000, 16'h3F80, 4'd5, 2,  16'h3F80, 1'b0, 3,  5'h11, 16'hBF80);
        vecs[2]  = mk(1'b0, 5'h14, 16'h1234, 16'h00FF, 4'hF, 1,  16'h12DF, 1'b0, 2,  5'h14, 16'h00FF);
        vecs[3]  = mk(1'b1, 5'h12, 16'hABCD, 16'h0F0F, 4'd1, 15, 16'hA4D0, 1'b0, 16, 5'h12, 16'h0F0F);
        vecs[4]  = mk(1'b0, 5'h15, 16'h0000, 16'h5555, 4'd7, 4,  16'h5540, 1'b0, 5,  5'h15, 16'h5555);
        vecs[5]  = mk(1'b0, 5'h08, 16'h1111, 16'h2222, 4'd2, 1,  16'h0000, 1'b1, 0,  5'h00, 16'h0000);
        vecs[6]  = mk(1'b1, 5'h16, 16'h1111, 16'h8001, 4'd9, 1,  16'h1101, 1'b0, 2,  5'h11, 16'h0001);
        vecs[7]  = mk(1'b0, 5'h11, 16'h0F00, 16'h00F0, 4'd8, 0,  16'h0000, 1'b1, MAX_LAT, 5'h11, 16'h00F0);
        vecs[8]  = mk(1'b1, 5'h1F, 16'hFFFF, 16'hFFFF, 4'd4, 1,  16'h0000, 1'b1, 0,  5'h00, 16'h0000);
        vecs[9]  = mk(1'b1, 5'h10, 16'h0001, 16'h0002, 4'd6, 1,  16'h0000, 1'b1, 0,  5'h00, 16'h0000);
        vecs[10] = mk(1'b0, 5'h11, 16'h0F00, 16'h00F0, 4'hA, 1,  16'h0FE1, 1'b0, 2,  5'h11, 16'h00F0);

        // Reset state
        @(negedge clk);
        check("rst_fpu_en", {31'd0, fpu_en}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
        check("rst_fpu_instr", {27'd0, fpu_instr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Tie after reset: req0 first, then strict alternation while both stay valid
        do_reset();
        @(negedge clk);
        stub_lat = 1;
        present(1'b0, 5'h13, 16'h0000, 16'h0001, 4'd1);
        present(1'b1, 5'h14, 16'h1234, 16'h00FF, 4'd2);
        req_valid = 2'b11;
        #1;
        check("t2_first_grant", {30'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!rsp_valid && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("t2_rsp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("t2_rsp_id_%0d", k), {31'd0, rsp_id}, k % 2);
            check($sformatf("t2_rsp_rd_%0d", k), {28'd0, rsp_rd}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("t2_rsp_result_%0d", k), {16'd0, rsp_result},
                  (k % 2 == 0) ? 32'h3F80 : 32'h12DF);
            rsp_ready = 1'b1;
            #1;
            check($sformatf("t2_no_grant_resp_%0d", k), {30'd0, req_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            if (k == 3) begin
                req_valid = 2'b00;
            end else begin
                #1;
                check($sformatf("t2_next_grant_%0d", k), {30'd0, req_ready},
                      (k % 2 == 0) ? 32'd2 : 32'd1);
            end
        end
        @(negedge clk);
        check("t2_end_busy", {31'd0, busy}, 32'd0);

        // Response stall: fields stable and no grants while rsp_ready is low
        @(negedge clk);
        stub_lat = 2;
        present(1'b0, 5'h11, 16'h0F00, 16'h00F0, 4'd6);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t6_hold_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
            check($sformatf("t6_hold_result_%0d", k), {16'd0, rsp_result}, 32'h0FE1);
            check($sformatf("t6_hold_rd_%0d", k), {28'd0, rsp_rd}, 32'd6);
            check($sformatf("t6_hold_id_%0d", k), {31'd0, rsp_id}, 32'd0);
            check($sformatf("t6_hold_ready_%0d", k), {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t6_release_busy", {31'd0, busy}, 32'd0);

        // Reset pulse while waiting on a never-completing op
        @(negedge clk);
        stub_lat = 0;
        present(1'b1, 5'h15, 16'h0000, 16'h1234, 4'd4);
        req_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("t6_wait_fpu_en", {31'd0, fpu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_fpu_en", {31'd0, fpu_en}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid || fpu_en) seen_rsp++;
        end
        check("t6_post_rst_quiet", seen_rsp, 0);
        check("t6_post_rst_busy", {31'd0, busy}, 32'd0);

        run_vec(11, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
